// File: rtl/esp8266_frame_decode_pkg.sv
// Shared constants and FSM state encoding for the ESP8266 reply decoders.
package esp8266_frame_decode_pkg;

    localparam logic [7:0] AsciiK    = 8'h4B;
    localparam logic [7:0] AsciiCr   = 8'h0D;
    localparam logic [7:0] AsciiZero = 8'h30;
    localparam logic [7:0] AsciiOne  = 8'h31;

    typedef enum logic [2:0] {
        StHunt,
        StSkip,
        StCap,
        StEnd,
        StCommit,
        StAbort
    } state_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/esp8266_rx_strobe.sv
// Turns the UART busy level into a one-cycle byte-valid strobe on its falling edge.
module esp8266_rx_strobe (
    input  logic clk,
    input  logic rst,
    input  logic rx_int,
    output logic stb
);

    logic rx_int_q;

    // History starts high so a line already low at reset release still yields one strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_int_q <= 1'b1;
        end else begin
            rx_int_q <= rx_int;
        end
    end

    assign stb = rx_int_q & ~rx_int;

endmodule

// File: rtl/esp8266_frame_decode.sv
// Frame decoder: hunt marker, skip header, capture payload, check terminator, then commit.
module esp8266_frame_decode
    import esp8266_frame_decode_pkg::*;
#(
    parameter int unsigned NBYTES  = 4,
    parameter int unsigned SKIP    = 4,
    parameter int unsigned NCH     = 4,
    parameter logic [7:0]  MARK    = AsciiK,
    parameter logic [7:0]  TERM    = AsciiCr,
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_int,
    input  logic [7:0]            rx_data,
    output logic [8*NBYTES-1:0]   data,
    output logic [NCH-1:0]        ch_out,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int unsigned SkipW = cnt_width((SKIP > 0) ? SKIP - 1 : 0);
    localparam int unsigned IdxW  = cnt_width(NBYTES - 1);
    localparam int unsigned TmoW  = cnt_width(TIMEOUT);

    localparam logic [SkipW-1:0] SkipLast = SkipW'(SKIP - 1);
    localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NBYTES - 1);
    localparam logic [TmoW-1:0]  TmoMax   = TmoW'(TIMEOUT);

    logic stb;

    state_e                   state_q, state_d;
    logic [SkipW-1:0]         skip_q, skip_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    logic [TmoW-1:0]          tmo_q, tmo_d;
    logic [NBYTES-1:0][7:0]   shadow_q, shadow_d;
    logic [8*NBYTES-1:0]      data_q, data_d;
    logic [NCH-1:0]           ch_q, ch_d;
    logic                     ok_q, err_q;
    logic                     tmo_hit;
    logic                     is_term;

    esp8266_rx_strobe u_rx_strobe (
        .clk    (clk),
        .rst    (rst),
        .rx_int (rx_int),
        .stb    (stb)
    );

    assign tmo_hit = (tmo_q == TmoMax);
    assign is_term = (rx_data == TERM);

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;

        unique case (state_q)
            StHunt: begin
                if (stb && rx_data == MARK) begin
                    skip_d  = '0;
                    idx_d   = '0;
                    state_d = (SKIP == 0) ? StCap : StSkip;
                end
            end
            StSkip: begin
                if (stb) begin
                    if (is_term) begin
                        state_d = StAbort;
                    end else if (skip_q == SkipLast) begin
                        state_d = StCap;
                    end else begin
                        skip_d = skip_q + SkipW'(1);
                    end
                end else if (tmo_hit) begin
                    state_d = StAbort;
                end
            end
            StCap: begin
                if (stb) begin
                    if (is_term) begin
                        state_d = StAbort;
                    end else begin
                        // A marker byte here is ordinary payload; no resync mid-frame.
                        shadow_d[idx_q] = rx_data;
                        if (idx_q == IdxLast) begin
                            state_d = StEnd;
                        end else begin
                            idx_d = idx_q + IdxW'(1);
                        end
                    end
                end else if (tmo_hit) begin
                    state_d = StAbort;
                end
            end
            StEnd: begin
                if (stb) begin
                    state_d = is_term ? StCommit : StAbort;
                end else if (tmo_hit) begin
                    state_d = StAbort;
                end
            end
            StCommit: state_d = StHunt;
            StAbort:  state_d = StHunt;
            default:  state_d = StHunt;
        endcase
    end

    // Inter-byte timer: cleared by every strobe, saturates at TIMEOUT, idle outside a frame.
    always_comb begin
        tmo_d = tmo_q;
        if (stb || !(state_q inside {StSkip, StCap, StEnd})) begin
            tmo_d = '0;
        end else if (!tmo_hit) begin
            tmo_d = tmo_q + TmoW'(1);
        end
    end

    // Outputs load on the edge that enters COMMIT, so data and frame_ok appear together.
    always_comb begin
        data_d = data_q;
        ch_d   = ch_q;
        if (state_d == StCommit) begin
            data_d = shadow_q;
            for (int i = 0; i < NCH; i++) begin
                ch_d[i] = (shadow_q[i] == AsciiOne);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StHunt;
            skip_q   <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            shadow_q <= '0;
            data_q   <= {NBYTES{AsciiZero}};
            ch_q     <= '0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            idx_q    <= idx_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            ch_q     <= ch_d;
            ok_q     <= (state_d == StCommit);
            err_q    <= (state_d == StAbort);
        end
    end

    assign data      = data_q;
    assign ch_out    = ch_q;
    assign frame_ok  = ok_q;
    assign frame_err = err_q;
    assign busy      = (state_q != StHunt);

endmodule

// File: tb/tb_esp8266_frame_decode.sv
// Randomized bench for esp8266_frame_decode with a byte-level frame model and per-cycle compare.
module tb_esp8266_frame_decode;

    localparam int unsigned NBYTES  = 4;
    localparam int unsigned SKIP    = 4;
    localparam int unsigned NCH     = 4;
    localparam int unsigned TIMEOUT = 60;
    localparam logic [7:0]  MARK    = 8'h4B;
    localparam logic [7:0]  TERM    = 8'h0D;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_int = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic [31:0] data;
    logic [3:0]  ch_out;
    logic        frame_ok, frame_err, busy;

    int checks = 0;
    int failures = 0;
    int err_seen = 0;
    int ok_seen = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    esp8266_frame_decode #(
        .NBYTES  (NBYTES),
        .SKIP    (SKIP),
        .NCH     (NCH),
        .MARK    (MARK),
        .TERM    (TERM),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_int    (rx_int),
        .rx_data   (rx_data),
        .data      (data),
        .ch_out    (ch_out),
        .frame_ok  (frame_ok),
        .frame_err (frame_err),
        .busy      (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ch_of(input logic [31:0] d);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) r[i] = (d[8*i +: 8] == 8'h31);
        return r;
    endfunction

    // Model: bytes since marker are collected; frame judged when the terminator slot arrives.
    bit          m_prev = 1'b1;
    bit          m_in = 1'b0;
    bit          m_close = 1'b0;
    int          m_idle = 0;
    bq_t         m_got;
    logic [31:0] m_data = 32'h30303030;
    bit          m_ok = 1'b0;
    bit          m_err = 1'b0;

    always @(posedge clk) begin
        bit s;
        m_ok  = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_prev  = 1'b1;
            m_in    = 1'b0;
            m_close = 1'b0;
            m_data  = 32'h30303030;
        end else begin
            s = m_prev && !rx_int;
            m_prev = rx_int;
            if (m_close) begin
                m_close = 1'b0;
            end else if (m_in) begin
                if (s) begin
                    m_idle = 0;
                    if (m_got.size() < SKIP + NBYTES) begin
                        if (rx_data == TERM) begin
                            m_err = 1'b1;
                        end else begin
                            m_got.push_back(rx_data);
                        end
                    end else if (rx_data == TERM) begin
                        for (int i = 0; i < NBYTES; i++) m_data[8*i +: 8] = m_got[SKIP + i];
                        m_ok = 1'b1;
                    end else begin
                        m_err = 1'b1;
                    end
                end else if (m_idle == TIMEOUT) begin
                    m_err = 1'b1;
                end else begin
                    m_idle++;
                end
                if (m_ok || m_err) begin
                    m_in    = 1'b0;
                    m_close = 1'b1;
                end
            end else if (s && rx_data == MARK) begin
                m_in   = 1'b1;
                m_idle = 0;
                m_got.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("frame_ok", {31'd0, frame_ok}, {31'd0, m_ok});
            chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
            chk("busy", {31'd0, busy}, {31'd0, m_in | m_close});
            chk("data", data, m_data);
            chk("ch_out", {28'd0, ch_out}, {28'd0, ch_of(m_data)});
            if (frame_ok === 1'b1) ok_seen++;
            if (frame_err === 1'b1) err_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int lo);
        rx_int = 1'b1;
        tick($urandom_range(1, 3));
        rx_data = b;
        rx_int  = 1'b0;
        tick(lo);
    endtask

    task automatic send_seq(input bq_t f, input int last_lo);
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], (i == f.size() - 1) ? last_lo : int'($urandom_range(2, 4)));
        end
    endtask

    function automatic logic [7:0] rnd_pl();
        case ($urandom_range(0, 3))
            0:       return 8'h30;
            1:       return 8'h31;
            2:       return MARK;
            default: return 8'($urandom_range(8'h20, 8'h7E));
        endcase
    endfunction

    // Marker, random header, n payload bytes from pl (byte 0 first), optional terminator.
    function automatic bq_t mk(input logic [31:0] pl, input int n, input bit term);
        bq_t f;
        f.push_back(MARK);
        for (int i = 0; i < SKIP; i++) f.push_back(8'($urandom_range(8'h20, 8'h7E)));
        for (int i = 0; i < n; i++) f.push_back(pl[8*i +: 8]);
        if (term) f.push_back(TERM);
        return f;
    endfunction

    initial begin
        bq_t f;
        int  e0, o0, mode, pos, g;
        logic [31:0] pl;

        tick(2);
        chk_en = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
        chk("reset_data", data, 32'h30303030);
        chk("reset_ch", {28'd0, ch_out}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ok", {31'd0, frame_ok}, 32'd0);

        send_seq(mk(32'h31313031, 4, 1'b1), 1);
        chk("good_ok_latency", {31'd0, frame_ok}, 32'd1);
        chk("good_data", data, 32'h31313031);
        chk("good_ch", {28'd0, ch_out}, 32'b1101);
        tick(3);

        send_seq(mk(32'h00003131, 2, 1'b1), 1);
        chk("short_err", {31'd0, frame_err}, 32'd1);
        chk("short_data_kept", data, 32'h31313031);
        chk("short_ch_kept", {28'd0, ch_out}, 32'b1101);
        tick(3);

        send_seq(mk(32'h30304B30, 4, 1'b1), 1);
        chk("mark_payload_data", data, 32'h30304B30);
        chk("mark_payload_ch", {28'd0, ch_out}, 32'd0);
        tick(3);

        e0 = err_seen;
        send_seq(mk(32'h00000031, 1, 1'b0), 2);
        tick(TIMEOUT + 10);
        chk("timeout_err_count", e0 < err_seen ? err_seen - e0 : 0, 32'd1);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        o0 = ok_seen;
        send_seq(mk(32'h30313031, 4, 1'b1), 4);
        chk("after_timeout_commit", o0 < ok_seen ? ok_seen - o0 : 0, 32'd1);
        chk("after_timeout_data", data, 32'h30313031);
        tick(3);

        e0 = err_seen;
        o0 = ok_seen;
        send_seq(mk(32'h00003131, 2, 1'b0), 2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("rst_mid_no_pulses", (err_seen - e0) + (ok_seen - o0), 32'd0);
        chk("rst_mid_data", data, 32'h30303030);
        send_seq(mk(32'h31303030, 4, 1'b1), 3);
        chk("rst_then_commit", data, 32'h31303030);
        tick(3);

        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < NBYTES; i++) pl[8*i +: 8] = rnd_pl();
            f = mk(pl, NBYTES, 1'b1);
            mode = $urandom_range(0, 9);
            case (mode)
                6: begin
                    pos = $urandom_range(1, f.size() - 2);
                    f[pos] = TERM;
                    f = f[0:pos];
                    send_seq(f, 3);
                end
                7: begin
                    f[f.size() - 1] = rnd_pl();
                    send_seq(f, 3);
                end
                8: begin
                    repeat ($urandom_range(1, 3)) send_byte(8'($urandom_range(0, 255)), 2);
                    send_seq(f, 3);
                end
                9: begin
                    pos = $urandom_range(1, f.size() - 1);
                    for (int i = 0; i < f.size(); i++) begin
                        if (i == pos) begin
                            g = int'(TIMEOUT) - 6 + int'($urandom_range(0, 10));
                            tick(g);
                        end
                        send_byte(f[i], 2);
                    end
                end
                default: send_seq(f, 3);
            endcase
            tick($urandom_range(1, 5));
        end

        tick(TIMEOUT + 10);
        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
